// File: rtl/ld_stream_unit_if.sv
// Bus bundle for ld_stream_unit: descriptor request channels, memory read port
// and the tagged output stream. The DUT takes the slave view, the environment the master view.
interface ld_stream_unit_if #(
    parameter int NUM_CH       = 4,
    parameter int WIDTH_ADDR   = 8,
    parameter int WIDTH_LENGTH = 8,
    parameter int WIDTH_DATA   = 32
);
    localparam int WIDTH_CH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]              I_Req_Valid;
    logic [NUM_CH-1:0]              O_Req_Ready;
    logic [2*NUM_CH-1:0]            I_Req_Mode;
    logic [WIDTH_ADDR*NUM_CH-1:0]   I_Req_Base;
    logic [WIDTH_ADDR*NUM_CH-1:0]   I_Req_Stride;
    logic [WIDTH_LENGTH*NUM_CH-1:0] I_Req_Length;

    logic                           O_Req;
    logic [1:0]                     O_AccessMode;
    logic [WIDTH_ADDR-1:0]          O_Address;
    logic                           I_Ld_Valid;
    logic [WIDTH_DATA-1:0]          I_Ld_Data;

    logic                           O_Valid;
    logic [WIDTH_DATA-1:0]          O_Data;
    logic [WIDTH_CH-1:0]            O_Ch;
    logic                           O_Last;
    logic                           I_Nack;

    modport slave (
        input  I_Req_Valid, I_Req_Mode, I_Req_Base, I_Req_Stride, I_Req_Length,
        input  I_Ld_Valid, I_Ld_Data, I_Nack,
        output O_Req_Ready, O_Req, O_AccessMode, O_Address,
        output O_Valid, O_Data, O_Ch, O_Last
    );

    modport master (
        output I_Req_Valid, I_Req_Mode, I_Req_Base, I_Req_Stride, I_Req_Length,
        output I_Ld_Valid, I_Ld_Data, I_Nack,
        input  O_Req_Ready, O_Req, O_AccessMode, O_Address,
        input  O_Valid, O_Data, O_Ch, O_Last
    );
endinterface

// File: rtl/ld_stream_unit.sv
// Multi-channel strided load unit: round-robin descriptor intake into a ring queue,
// a sequencing engine issuing reads or synthesising values, and a 2-entry output skid.
module ld_stream_unit #(
    parameter int NUM_CH       = 4,
    parameter int WIDTH_ADDR   = 8,
    parameter int WIDTH_LENGTH = 8,
    parameter int WIDTH_DATA   = 32,
    parameter int DEPTH_DESC   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Boot,
    input  logic [WIDTH_DATA-1:0] I_Shared_Data,
    ld_stream_unit_if.slave       bus,
    output logic                  O_End_Load,
    output logic                  O_Busy,
    output logic                  O_Full,
    output logic                  O_Empty
);
    localparam int WIDTH_CH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WIDTH_PTR = $clog2(DEPTH_DESC);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_GEN, ST_DRAIN, ST_DONE} state_t;

    logic [1:0]              w_ch_mode   [NUM_CH];
    logic [WIDTH_ADDR-1:0]   w_ch_base   [NUM_CH];
    logic [WIDTH_ADDR-1:0]   w_ch_stride [NUM_CH];
    logic [WIDTH_LENGTH-1:0] w_ch_len    [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_ch_mode[gi]   = bus.I_Req_Mode[gi*2 +: 2];
        assign w_ch_base[gi]   = bus.I_Req_Base[gi*WIDTH_ADDR +: WIDTH_ADDR];
        assign w_ch_stride[gi] = bus.I_Req_Stride[gi*WIDTH_ADDR +: WIDTH_ADDR];
        assign w_ch_len[gi]    = bus.I_Req_Length[gi*WIDTH_LENGTH +: WIDTH_LENGTH];
    end

    logic                r_boot;
    logic [WIDTH_CH-1:0] r_rr;
    logic [WIDTH_CH-1:0] w_gidx, w_idx;
    logic                w_found, w_push, w_full, w_empty;
    logic [NUM_CH-1:0]   w_grant;

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = WIDTH_CH'((int'(r_rr) + k) % NUM_CH);
            if (!w_found && bus.I_Req_Valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    assign w_push = r_boot & ~w_full & w_found;

    always_comb begin
        w_grant = '0;
        if (w_push) w_grant[w_gidx] = 1'b1;
    end

    // Descriptor ring: extra pointer bit distinguishes full from empty.
    logic [1:0]              r_q_mode   [DEPTH_DESC];
    logic [WIDTH_ADDR-1:0]   r_q_base   [DEPTH_DESC];
    logic [WIDTH_ADDR-1:0]   r_q_stride [DEPTH_DESC];
    logic [WIDTH_LENGTH-1:0] r_q_len    [DEPTH_DESC];
    logic [WIDTH_CH-1:0]     r_q_ch     [DEPTH_DESC];
    logic [WIDTH_PTR:0]      r_wr_ptr, r_rd_ptr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[WIDTH_PTR] != r_rd_ptr[WIDTH_PTR]) &&
                     (r_wr_ptr[WIDTH_PTR-1:0] == r_rd_ptr[WIDTH_PTR-1:0]);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_mode[r_wr_ptr[WIDTH_PTR-1:0]]   <= w_ch_mode[w_gidx];
            r_q_base[r_wr_ptr[WIDTH_PTR-1:0]]   <= w_ch_base[w_gidx];
            r_q_stride[r_wr_ptr[WIDTH_PTR-1:0]] <= w_ch_stride[w_gidx];
            r_q_len[r_wr_ptr[WIDTH_PTR-1:0]]    <= w_ch_len[w_gidx];
            r_q_ch[r_wr_ptr[WIDTH_PTR-1:0]]     <= w_gidx;
        end
    end

    state_t                  r_state, w_state_next;
    logic [WIDTH_ADDR-1:0]   r_addr, r_stride;
    logic [WIDTH_LENGTH-1:0] r_cnt;
    logic [1:0]              r_mode, r_out, r_sk_cnt;
    logic [WIDTH_CH-1:0]     r_ch;
    logic                    r_pend_last, r_end;
    logic                    w_pop, w_issue, w_gen_push, w_ld_take, w_credit_ok;
    logic                    w_sk_valid, w_sk_pop, w_sk_push, w_sk_room, w_sk_lin;
    logic [WIDTH_DATA-1:0]   w_sk_din;
    logic [WIDTH_DATA-1:0]   r_sk_data [2];
    logic [WIDTH_CH-1:0]     r_sk_ch   [2];
    logic                    r_sk_last [2];
    logic                    r_sk_wp, r_sk_rp;

    wire [1:0]              w_hd_mode = r_q_mode[r_rd_ptr[WIDTH_PTR-1:0]];
    wire [WIDTH_LENGTH-1:0] w_hd_len  = r_q_len[r_rd_ptr[WIDTH_PTR-1:0]];

    assign w_sk_valid = (r_sk_cnt != 2'd0);
    assign w_sk_pop   = w_sk_valid & ~bus.I_Nack;
    assign w_sk_room  = (r_sk_cnt != 2'd2) | w_sk_pop;
    assign w_ld_take  = bus.I_Ld_Valid & (r_out != 2'd0);
    // In-flight reads plus buffered elements never exceed two; a pop this cycle frees a slot.
    assign w_credit_ok = (3'(r_out) + 3'(r_sk_cnt)) < (3'd2 + 3'(w_sk_pop));

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_gen_push   = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_pop = 1'b1;
                if (w_hd_len == '0)                             w_state_next = ST_DONE;
                else if (w_hd_mode == 2'b01 || w_hd_mode == 2'b10) w_state_next = ST_GEN;
                else                                            w_state_next = ST_LOAD;
            end
            ST_LOAD: if (r_cnt != '0 && w_credit_ok) begin
                w_issue = 1'b1;
                if (r_cnt == WIDTH_LENGTH'(1)) w_state_next = ST_DRAIN;
            end
            ST_GEN: if (w_sk_room) begin
                w_gen_push = 1'b1;
                if (r_cnt == WIDTH_LENGTH'(1)) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: if (w_sk_pop && r_sk_last[r_sk_rp]) w_state_next = ST_IDLE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_boot      <= 1'b0;
            r_rr        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_addr      <= '0;
            r_stride    <= '0;
            r_cnt       <= '0;
            r_mode      <= '0;
            r_ch        <= '0;
            r_pend_last <= 1'b0;
            r_out       <= '0;
            r_end       <= 1'b0;
        end else begin
            r_boot <= r_boot | I_Boot;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (WIDTH_PTR+1)'(1);
                r_rr     <= (w_gidx == WIDTH_CH'(NUM_CH-1)) ? '0 : w_gidx + WIDTH_CH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (WIDTH_PTR+1)'(1);
                r_addr   <= r_q_base[r_rd_ptr[WIDTH_PTR-1:0]];
                r_stride <= r_q_stride[r_rd_ptr[WIDTH_PTR-1:0]];
                r_cnt    <= w_hd_len;
                r_mode   <= w_hd_mode;
                r_ch     <= r_q_ch[r_rd_ptr[WIDTH_PTR-1:0]];
            end else if (w_issue) begin
                r_addr      <= r_addr + r_stride;
                r_cnt       <= r_cnt - WIDTH_LENGTH'(1);
                r_pend_last <= (r_cnt == WIDTH_LENGTH'(1));
            end else if (w_gen_push) begin
                r_cnt <= r_cnt - WIDTH_LENGTH'(1);
            end
            r_out <= r_out + 2'(w_issue) - 2'(w_ld_take);
            r_end <= w_sk_pop & r_sk_last[r_sk_rp];
        end
    end

    // Only one source feeds the skid at a time: reads never overlap generation.
    assign w_sk_push = w_ld_take | w_gen_push;
    assign w_sk_din  = w_gen_push ? ((r_mode == 2'b01) ? I_Shared_Data : '0) : bus.I_Ld_Data;
    assign w_sk_lin  = w_gen_push ? (r_cnt == WIDTH_LENGTH'(1)) : r_pend_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sk_wp  <= 1'b0;
            r_sk_rp  <= 1'b0;
            r_sk_cnt <= '0;
        end else begin
            if (w_sk_push) begin
                r_sk_data[r_sk_wp] <= w_sk_din;
                r_sk_ch[r_sk_wp]   <= r_ch;
                r_sk_last[r_sk_wp] <= w_sk_lin;
                r_sk_wp            <= ~r_sk_wp;
            end
            if (w_sk_pop) r_sk_rp <= ~r_sk_rp;
            r_sk_cnt <= r_sk_cnt + 2'(w_sk_push) - 2'(w_sk_pop);
        end
    end

    assign bus.O_Req_Ready  = w_grant;
    assign bus.O_Req        = w_issue;
    assign bus.O_AccessMode = w_issue ? 2'b01 : 2'b00;
    assign bus.O_Address    = r_addr;
    assign bus.O_Valid      = w_sk_valid;
    assign bus.O_Data       = w_sk_valid ? r_sk_data[r_sk_rp] : '0;
    assign bus.O_Ch         = w_sk_valid ? r_sk_ch[r_sk_rp] : '0;
    assign bus.O_Last       = w_sk_valid & r_sk_last[r_sk_rp];

    assign O_End_Load = r_end | (r_state == ST_DONE);
    assign O_Busy     = ~w_empty | (r_state != ST_IDLE) | w_sk_valid;
    assign O_Full     = w_full;
    assign O_Empty    = w_empty;
endmodule

// File: tb/tb_ld_stream_unit.sv
// Directed bench for ld_stream_unit: memory returns addr+0x100 one cycle after each read;
// a negedge monitor logs reads, transfers and completion pulses.
module tb_ld_stream_unit;
    localparam int NUM_CH = 4;
    localparam int WA = 8;
    localparam int WL = 8;
    localparam int WD = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          boot  = 1'b0;
    logic [WD-1:0] shared = '0;
    logic          end_load, busy, full, empty;

    ld_stream_unit_if #(.NUM_CH(NUM_CH), .WIDTH_ADDR(WA), .WIDTH_LENGTH(WL), .WIDTH_DATA(WD)) bus ();

    ld_stream_unit #(.NUM_CH(NUM_CH), .WIDTH_ADDR(WA), .WIDTH_LENGTH(WL), .WIDTH_DATA(WD), .DEPTH_DESC(4)) dut (
        .clock(clock), .reset(reset), .I_Boot(boot), .I_Shared_Data(shared), .bus(bus),
        .O_End_Load(end_load), .O_Busy(busy), .O_Full(full), .O_Empty(empty)
    );

    always #5 clock = ~clock;

    logic          mem_v = 1'b0;
    logic [WD-1:0] mem_d = '0;
    always @(posedge clock) begin
        mem_v <= bus.O_Req;
        mem_d <= 32'(bus.O_Address) + 32'h100;
    end
    assign bus.I_Ld_Valid = mem_v;
    assign bus.I_Ld_Data  = mem_d;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [WA-1:0] q_addr[$];
    int            q_req_cyc[$];
    logic [WD-1:0] q_data[$];
    int            q_ch[$];
    int            q_last[$];
    int            q_val_cyc[$];
    int            n_end = 0;
    int            bad_am = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.O_Req) begin
                q_addr.push_back(bus.O_Address);
                q_req_cyc.push_back(cyc);
            end
            if (bus.O_AccessMode !== (bus.O_Req ? 2'b01 : 2'b00)) bad_am++;
            if (bus.O_Valid && !bus.I_Nack) begin
                q_data.push_back(bus.O_Data);
                q_ch.push_back(int'(bus.O_Ch));
                q_last.push_back(int'(bus.O_Last));
                q_val_cyc.push_back(cyc);
            end
            if (end_load) n_end++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int a0, d0, e0, g, found;
    int grants[$];
    logic [WD-1:0] exp_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input int ch, input logic [1:0] mode, input logic [7:0] base,
                        input logic [7:0] stride, input logic [7:0] len, output int gcyc);
        int got;
        got = 0;
        bus.I_Req_Mode[ch*2 +: 2]     = mode;
        bus.I_Req_Base[ch*WA +: WA]   = base;
        bus.I_Req_Stride[ch*WA +: WA] = stride;
        bus.I_Req_Length[ch*WL +: WL] = len;
        bus.I_Req_Valid[ch]           = 1'b1;
        for (int i = 0; i < 60 && got == 0; i++) begin
            #1;
            if (bus.O_Req_Ready[ch]) got = 1;
            @(posedge clock);
            #1;
        end
        gcyc = cyc;
        bus.I_Req_Valid[ch] = 1'b0;
        check($sformatf("grant_ch%0d", ch), 32'(got), 32'd1);
    endtask

    task automatic wait_ends(input int prev, input int n);
        for (int i = 0; i < 400 && (n_end - prev) < n; i++) tick(1);
        tick(3);
    endtask

    initial begin
        bus.I_Req_Valid = '0; bus.I_Req_Mode = '0; bus.I_Req_Base = '0;
        bus.I_Req_Stride = '0; bus.I_Req_Length = '0; bus.I_Nack = 1'b0;
        tick(3);
        bus.I_Req_Valid = 4'b0001;
        bus.I_Req_Length[0 +: WL] = 8'd1;
        reset = 1'b0;
        tick(2);
        #1;
        check("rst_valid", 32'(bus.O_Valid), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_req", 32'(bus.O_Req), 0);
        check("rst_end", 32'(end_load), 0);
        check("noboot_ready", 32'(bus.O_Req_Ready), 0);
        bus.I_Req_Valid = '0;
        boot = 1'b1; tick(1); boot = 1'b0;

        // Memory load, ch1, with latency and throughput checks
        a0 = q_addr.size(); d0 = q_data.size(); e0 = n_end;
        send(1, 2'b00, 8'h10, 8'h04, 8'd3, g);
        wait_ends(e0, 1);
        check("t1_nout", 32'(q_data.size() - d0), 3);
        check("t1_nreq", 32'(q_addr.size() - a0), 3);
        for (int i = 0; i < 3; i++) begin
            if (q_addr.size() > a0 + i) check($sformatf("t1_addr%0d", i), 32'(q_addr[a0+i]), 32'h10 + 32'(4*i));
            if (q_data.size() > d0 + i) begin
                check($sformatf("t1_data%0d", i), q_data[d0+i], 32'h110 + 32'(4*i));
                check($sformatf("t1_ch%0d", i), 32'(q_ch[d0+i]), 1);
                check($sformatf("t1_last%0d", i), 32'(q_last[d0+i]), (i == 2) ? 1 : 0);
            end
        end
        if (q_addr.size() > a0) check("t1_req_lat", 32'(q_req_cyc[a0] - g), 1);
        if (q_data.size() > d0 + 2) begin
            check("t1_val_lat", 32'(q_val_cyc[d0] - g), 3);
            check("t1_thru", 32'(q_val_cyc[d0+2] - q_val_cyc[d0]), 2);
        end
        check("t1_ends", 32'(n_end - e0), 1);

        // Round-robin with the engine stalled until the queue fills
        reset = 1'b1; tick(2); reset = 1'b0;
        bus.I_Nack = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.I_Req_Mode[c*2 +: 2]     = 2'b00;
            bus.I_Req_Base[c*WA +: WA]   = 8'(32 * c);
            bus.I_Req_Stride[c*WA +: WA] = 8'd1;
            bus.I_Req_Length[c*WL +: WL] = 8'd1;
        end
        bus.I_Req_Valid = 4'b1111;
        boot = 1'b1; tick(1); boot = 1'b0;
        a0 = q_addr.size(); d0 = q_data.size(); e0 = n_end;
        grants.delete();
        for (int i = 0; i < 8; i++) begin
            #1;
            for (int b = 0; b < NUM_CH; b++) if (bus.O_Req_Ready[b]) grants.push_back(b);
            @(posedge clock);
            #1;
        end
        #1;
        check("t2_ngrants", 32'(grants.size()), 5);
        for (int i = 0; i < 5; i++)
            if (grants.size() > i) check($sformatf("t2_grant%0d", i), 32'(grants[i]), 32'(i % NUM_CH));
        check("t2_full", 32'(full), 1);
        check("t2_ready_full", 32'(bus.O_Req_Ready), 0);
        check("t2_busy", 32'(busy), 1);
        bus.I_Req_Valid = '0;
        bus.I_Nack = 1'b0;
        wait_ends(e0, 5);
        check("t2_nout", 32'(q_data.size() - d0), 5);
        for (int i = 0; i < 5; i++) begin
            if (q_data.size() > d0 + i) begin
                check($sformatf("t2_ch%0d", i), 32'(q_ch[d0+i]), 32'(i % NUM_CH));
                check($sformatf("t2_data%0d", i), q_data[d0+i], 32'h100 + 32'(32 * (i % NUM_CH)));
                check($sformatf("t2_last%0d", i), 32'(q_last[d0+i]), 1);
            end
        end
        check("t2_ends", 32'(n_end - e0), 5);

        // Shared then zero mode, no memory traffic
        shared = 32'hDEADBEEF;
        a0 = q_addr.size(); d0 = q_data.size(); e0 = n_end;
        send(2, 2'b01, 8'h00, 8'h00, 8'd4, g);
        send(3, 2'b10, 8'h00, 8'h00, 8'd2, g);
        wait_ends(e0, 2);
        check("t3_nout", 32'(q_data.size() - d0), 6);
        check("t3_noreq", 32'(q_addr.size() - a0), 0);
        for (int i = 0; i < 6; i++) begin
            exp_d = (i < 4) ? 32'hDEADBEEF : 32'h0;
            if (q_data.size() > d0 + i) begin
                check($sformatf("t3_data%0d", i), q_data[d0+i], exp_d);
                check($sformatf("t3_ch%0d", i), 32'(q_ch[d0+i]), (i < 4) ? 2 : 3);
                check($sformatf("t3_last%0d", i), 32'(q_last[d0+i]), (i == 3 || i == 5) ? 1 : 0);
            end
        end

        // Consumer stall mid-stream of an 8-element load
        a0 = q_addr.size(); d0 = q_data.size(); e0 = n_end;
        send(0, 2'b00, 8'h40, 8'h01, 8'd8, g);
        for (int i = 0; i < 100 && (q_data.size() - d0) < 2; i++) tick(1);
        check("t4_started", 32'((q_data.size() - d0) >= 2), 1);
        bus.I_Nack = 1'b1;
        tick(10);
        check("t4_req_low", 32'(bus.O_Req), 0);
        check("t4_buffered", 32'((q_addr.size() - a0) - (q_data.size() - d0)), 2);
        check("t4_valid_held", 32'(bus.O_Valid), 1);
        bus.I_Nack = 1'b0;
        wait_ends(e0, 1);
        check("t4_nout", 32'(q_data.size() - d0), 8);
        for (int i = 0; i < 8; i++) begin
            if (q_data.size() > d0 + i) begin
                check($sformatf("t4_data%0d", i), q_data[d0+i], 32'h140 + 32'(i));
                check($sformatf("t4_last%0d", i), 32'(q_last[d0+i]), (i == 7) ? 1 : 0);
            end
        end

        // Address wrap, then a zero-length descriptor
        a0 = q_addr.size(); d0 = q_data.size(); e0 = n_end;
        send(1, 2'b11, 8'hF8, 8'h04, 8'd4, g);
        wait_ends(e0, 1);
        check("t5_nreq", 32'(q_addr.size() - a0), 4);
        for (int i = 0; i < 4; i++) begin
            if (q_addr.size() > a0 + i) check($sformatf("t5_addr%0d", i), 32'(q_addr[a0+i]), 32'(8'(8'hF8 + 8'(4*i))));
            if (q_data.size() > d0 + i) check($sformatf("t5_data%0d", i), q_data[d0+i], 32'h100 + 32'(8'(8'hF8 + 8'(4*i))));
        end
        a0 = q_addr.size(); d0 = q_data.size(); e0 = n_end;
        send(2, 2'b00, 8'h33, 8'h01, 8'd0, g);
        wait_ends(e0, 1);
        check("t5_len0_end", 32'(n_end - e0), 1);
        check("t5_len0_noval", 32'(q_data.size() - d0), 0);
        check("t5_len0_noreq", 32'(q_addr.size() - a0), 0);
        check("t5_idle", 32'(busy), 0);

        // Reset with a read in flight; the late response must be dropped
        send(0, 2'b00, 8'h80, 8'h01, 8'd8, g);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            #1;
            if (bus.O_Req) begin
                found = 1;
                reset = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        check("t6_req_seen", 32'(found), 1);
        check("t6_stray", 32'(bus.I_Ld_Valid), 1);
        d0 = q_data.size();
        tick(3);
        check("t6_valid", 32'(bus.O_Valid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_empty", 32'(empty), 1);
        check("t6_req", 32'(bus.O_Req), 0);
        check("t6_noout", 32'(q_data.size() - d0), 0);
        check("accessmode", 32'(bad_am), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
